// File: rtl/flash_byte_packer_pkg.sv
// Shared NPU load definitions: packed word geometry and the byte packer state encoding.
package flash_byte_packer_pkg;

   localparam int WORD_BYTES = 32;
   localparam int WORD_W     = 8 * WORD_BYTES;
   localparam int SLOT_W     = $clog2(WORD_BYTES);
   localparam int LEN_W      = 24;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FLUSH   = 2'd2,
      DONE    = 2'd3
   } state_e;

endpackage

// File: rtl/flash_byte_packer_if.sv
// Byte-stream-in / word-load-out bundle between the flash reader side and the packer.
interface flash_byte_packer_if #(
   parameter int WORD_W = flash_byte_packer_pkg::WORD_W
);
   logic              start;
   logic [23:0]       byte_num;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              load_en;
   logic [WORD_W-1:0] load_data;
   logic              frame_done;
   logic              busy;

   modport master (
      output start, byte_num, byte_valid, byte_data,
      input  load_en, load_data, frame_done, busy
   );

   modport slave (
      input  start, byte_num, byte_valid, byte_data,
      output load_en, load_data, frame_done, busy
   );
endinterface

// File: rtl/flash_byte_packer.sv
// Packs a flash read byte stream into WORD_BYTES-wide words, first byte at the LSB,
// zero-padding a trailing partial word and signalling the end of each frame.
module flash_byte_packer
   import flash_byte_packer_pkg::*;
#(
   parameter int WORD_BYTES = flash_byte_packer_pkg::WORD_BYTES,
   parameter int WORD_W     = flash_byte_packer_pkg::WORD_W
) (
   input logic                sys_clk,
   input logic                sys_rst,
   flash_byte_packer_if.slave bus
);

   state_e              state_q, state_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [LEN_W-1:0]    count_q, count_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [WORD_W-1:0]   stage_q, stage_d;
   logic [WORD_W-1:0]   hold_q, hold_d;
   logic [WORD_W-1:0]   loadData_q, loadData_d;
   logic                pendLoad_q, pendLoad_d;
   logic                frameDone_q, frameDone_d;
   logic                accept;
   logic                lastByte;
   logic                wordFull;

   assign accept   = (state_q == COLLECT) && bus.byte_valid && !bus.start;
   assign lastByte = (count_q + LEN_W'(1)) == len_q;
   assign wordFull = slot_q == SLOT_W'(WORD_BYTES - 1);

   // A completed word waits in hold_q so that a restart can clear the staging
   // register while an already scheduled load still delivers its data.
   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      count_d     = count_q;
      len_d       = len_q;
      stage_d     = stage_q;
      hold_d      = hold_q;
      pendLoad_d  = 1'b0;
      frameDone_d = 1'b0;
      loadData_d  = pendLoad_q ? hold_q : loadData_q;

      if (bus.start) begin
         len_d   = bus.byte_num;
         slot_d  = '0;
         count_d = '0;
         stage_d = '0;
         state_d = (bus.byte_num == '0) ? DONE : COLLECT;
      end else begin
         case (state_q)
            IDLE: begin
            end
            COLLECT: begin
               if (accept) begin
                  stage_d[{slot_q, 3'b000} +: 8] = bus.byte_data;
                  count_d = count_q + LEN_W'(1);
                  slot_d  = slot_q + SLOT_W'(1);
                  if (wordFull) begin
                     hold_d     = stage_d;
                     stage_d    = '0;
                     pendLoad_d = 1'b1;
                  end
                  if (lastByte) begin
                     state_d = wordFull ? DONE : FLUSH;
                  end
               end
            end
            FLUSH: begin
               hold_d     = stage_q;
               stage_d    = '0;
               pendLoad_d = 1'b1;
               state_d    = DONE;
            end
            DONE: begin
               frameDone_d = 1'b1;
               state_d     = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         count_q     <= '0;
         len_q       <= '0;
         stage_q     <= '0;
         hold_q      <= '0;
         loadData_q  <= '0;
         pendLoad_q  <= 1'b0;
         frameDone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         count_q     <= count_d;
         len_q       <= len_d;
         stage_q     <= stage_d;
         hold_q      <= hold_d;
         loadData_q  <= loadData_d;
         pendLoad_q  <= pendLoad_d;
         frameDone_q <= frameDone_d;
      end
   end

   assign bus.load_en    = pendLoad_q;
   assign bus.load_data  = loadData_q;
   assign bus.frame_done = frameDone_q;
   assign bus.busy       = (state_q != IDLE);

endmodule
